// File: rtl/idu_exu_pipe_reg.sv
// ID->EX pipeline register with valid/ready handshake, load-use bubble
// insertion, WB refresh of held operands and branch-flush squash.
module idu_exu_pipe_reg #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             id_valid,
   output logic             id_ready,
   input  logic [WIDTH-1:0] id_pc,
   input  logic [WIDTH-1:0] id_imm,
   input  logic [15:0]      id_ctrl,
   input  logic [4:0]       id_rf_raddr1,
   input  logic [4:0]       id_rf_raddr2,
   input  logic             id_rf_ren1,
   input  logic             id_rf_ren2,
   input  logic [WIDTH-1:0] id_rf_rdata1,
   input  logic [WIDTH-1:0] id_rf_rdata2,
   input  logic [4:0]       id_rf_waddr,
   input  logic             id_rf_we,
   input  logic             id_mem_re,
   output logic             ex_valid,
   input  logic             ex_ready,
   output logic [WIDTH-1:0] ex_pc,
   output logic [WIDTH-1:0] ex_imm,
   output logic [15:0]      ex_ctrl,
   output logic [4:0]       ex_rf_raddr1,
   output logic [4:0]       ex_rf_raddr2,
   output logic [WIDTH-1:0] ex_rf_rdata1,
   output logic [WIDTH-1:0] ex_rf_rdata2,
   output logic [4:0]       ex_rf_waddr,
   output logic             ex_rf_we,
   output logic             ex_mem_re,
   input  logic             flush,
   input  logic             wb_rf_we,
   input  logic [4:0]       wb_rf_waddr,
   input  logic [WIDTH-1:0] wb_rf_wdata,
   output logic [CNT_W-1:0] stall_cnt
);

   logic ex_we_q;
   logic ex_mre_q;
   logic can_upd;
   logic rs_match;
   logic hazard;

   // Handshake and load-use hazard detection against the load held in EX
   always_comb begin
      can_upd  = !ex_valid || ex_ready;
      rs_match = (id_rf_ren1 && (id_rf_raddr1 == ex_rf_waddr)) ||
                 (id_rf_ren2 && (id_rf_raddr2 == ex_rf_waddr));
      hazard   = ex_valid && ex_mre_q && ex_we_q && (ex_rf_waddr != 5'd0) &&
                 id_valid && rs_match;
      id_ready = can_upd && !hazard && !flush;
   end

   // Side-effect flags are qualified by valid so an empty slot never writes
   always_comb begin
      ex_rf_we  = ex_valid && ex_we_q;
      ex_mem_re = ex_valid && ex_mre_q;
   end

   // EX register update: flush > bubble > load > drain > hold with WB refresh
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid     <= 1'b0;
         ex_pc        <= '0;
         ex_imm       <= '0;
         ex_ctrl      <= '0;
         ex_rf_raddr1 <= '0;
         ex_rf_raddr2 <= '0;
         ex_rf_rdata1 <= '0;
         ex_rf_rdata2 <= '0;
         ex_rf_waddr  <= '0;
         ex_we_q      <= 1'b0;
         ex_mre_q     <= 1'b0;
         stall_cnt    <= '0;
      end else if (flush) begin
         ex_valid <= 1'b0;
      end else if (can_upd) begin
         if (hazard) begin
            ex_valid  <= 1'b0;
            stall_cnt <= stall_cnt + CNT_W'(1);
         end else if (id_valid) begin
            ex_valid     <= 1'b1;
            ex_pc        <= id_pc;
            ex_imm       <= id_imm;
            ex_ctrl      <= id_ctrl;
            ex_rf_raddr1 <= id_rf_raddr1;
            ex_rf_raddr2 <= id_rf_raddr2;
            ex_rf_rdata1 <= id_rf_rdata1;
            ex_rf_rdata2 <= id_rf_rdata2;
            ex_rf_waddr  <= id_rf_waddr;
            ex_we_q      <= id_rf_we;
            ex_mre_q     <= id_mem_re;
         end else begin
            ex_valid <= 1'b0;
         end
      end else begin
         if (wb_rf_we && (wb_rf_waddr != 5'd0) && (wb_rf_waddr == ex_rf_raddr1))
            ex_rf_rdata1 <= wb_rf_wdata;
         if (wb_rf_we && (wb_rf_waddr != 5'd0) && (wb_rf_waddr == ex_rf_raddr2))
            ex_rf_rdata2 <= wb_rf_wdata;
      end
   end

endmodule

// File: tb/tb_idu_exu_pipe_reg.sv
// Self-checking bench for idu_exu_pipe_reg: directed scenarios plus a
// randomized run against a transaction-level model of the EX slot.
module tb_idu_exu_pipe_reg;

   logic        clk, rst_n;
   logic        id_valid, id_ready;
   logic [31:0] id_pc, id_imm;
   logic [15:0] id_ctrl;
   logic [4:0]  id_rf_raddr1, id_rf_raddr2;
   logic        id_rf_ren1, id_rf_ren2;
   logic [31:0] id_rf_rdata1, id_rf_rdata2;
   logic [4:0]  id_rf_waddr;
   logic        id_rf_we, id_mem_re;
   logic        ex_valid, ex_ready;
   logic [31:0] ex_pc, ex_imm;
   logic [15:0] ex_ctrl;
   logic [4:0]  ex_rf_raddr1, ex_rf_raddr2;
   logic [31:0] ex_rf_rdata1, ex_rf_rdata2;
   logic [4:0]  ex_rf_waddr;
   logic        ex_rf_we, ex_mem_re;
   logic        flush;
   logic        wb_rf_we;
   logic [4:0]  wb_rf_waddr;
   logic [31:0] wb_rf_wdata;
   logic [31:0] stall_cnt;

   int checks = 0;
   int errors = 0;

   idu_exu_pipe_reg #(.WIDTH(32), .CNT_W(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .id_valid(id_valid), .id_ready(id_ready),
      .id_pc(id_pc), .id_imm(id_imm), .id_ctrl(id_ctrl),
      .id_rf_raddr1(id_rf_raddr1), .id_rf_raddr2(id_rf_raddr2),
      .id_rf_ren1(id_rf_ren1), .id_rf_ren2(id_rf_ren2),
      .id_rf_rdata1(id_rf_rdata1), .id_rf_rdata2(id_rf_rdata2),
      .id_rf_waddr(id_rf_waddr), .id_rf_we(id_rf_we), .id_mem_re(id_mem_re),
      .ex_valid(ex_valid), .ex_ready(ex_ready),
      .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_ctrl(ex_ctrl),
      .ex_rf_raddr1(ex_rf_raddr1), .ex_rf_raddr2(ex_rf_raddr2),
      .ex_rf_rdata1(ex_rf_rdata1), .ex_rf_rdata2(ex_rf_rdata2),
      .ex_rf_waddr(ex_rf_waddr), .ex_rf_we(ex_rf_we), .ex_mem_re(ex_mem_re),
      .flush(flush),
      .wb_rf_we(wb_rf_we), .wb_rf_waddr(wb_rf_waddr), .wb_rf_wdata(wb_rf_wdata),
      .stall_cnt(stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model of the instruction currently occupying EX
   typedef struct {
      logic        valid;
      logic [31:0] pc, imm;
      logic [15:0] ctrl;
      logic [4:0]  ra1, ra2, wa;
      logic [31:0] rd1, rd2;
      logic        we, mre;
   } ex_t;

   ex_t         m;
   logic [31:0] m_cnt;

   task automatic model_reset();
      m = '{default: '0};
      m_cnt = 0;
   endtask

   // The load sitting in EX writes a real register that ID wants to read
   function automatic logic model_hazard();
      logic reads;
      reads = (id_rf_ren1 && id_rf_raddr1 == m.wa) || (id_rf_ren2 && id_rf_raddr2 == m.wa);
      return m.valid && m.mre && m.we && m.wa != 0 && id_valid && reads;
   endfunction

   function automatic logic model_ready();
      return (!m.valid || ex_ready) && !model_hazard() && !flush;
   endfunction

   task automatic model_step();
      logic slot_free;
      slot_free = !m.valid || ex_ready;
      if (flush) m.valid = 1'b0;
      else if (slot_free && model_hazard()) begin
         m.valid = 1'b0;
         m_cnt = m_cnt + 1;
      end else if (slot_free && id_valid) begin
         m = '{valid: 1'b1, pc: id_pc, imm: id_imm, ctrl: id_ctrl,
               ra1: id_rf_raddr1, ra2: id_rf_raddr2, wa: id_rf_waddr,
               rd1: id_rf_rdata1, rd2: id_rf_rdata2, we: id_rf_we, mre: id_mem_re};
      end else if (slot_free) m.valid = 1'b0;
      else begin
         if (wb_rf_we && wb_rf_waddr != 0 && wb_rf_waddr == m.ra1) m.rd1 = wb_rf_wdata;
         if (wb_rf_we && wb_rf_waddr != 0 && wb_rf_waddr == m.ra2) m.rd2 = wb_rf_wdata;
      end
   endtask

   // Advance one clock, keeping the model in step; returns at the falling edge
   task automatic cycle();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic set_id(input logic [31:0] pc, input logic [4:0] ra1, input logic r1,
                         input logic [4:0] ra2, input logic r2, input logic [4:0] wa,
                         input logic we, input logic mre);
      id_valid = 1'b1; id_pc = pc; id_imm = $urandom; id_ctrl = 16'($urandom);
      id_rf_raddr1 = ra1; id_rf_ren1 = r1; id_rf_raddr2 = ra2; id_rf_ren2 = r2;
      id_rf_rdata1 = $urandom; id_rf_rdata2 = $urandom;
      id_rf_waddr = wa; id_rf_we = we; id_mem_re = mre;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; id_valid = 0; id_pc = 0; id_imm = 0; id_ctrl = 0;
      id_rf_raddr1 = 0; id_rf_raddr2 = 0; id_rf_ren1 = 0; id_rf_ren2 = 0;
      id_rf_rdata1 = 0; id_rf_rdata2 = 0; id_rf_waddr = 0; id_rf_we = 0; id_mem_re = 0;
      ex_ready = 1; flush = 0; wb_rf_we = 0; wb_rf_waddr = 0; wb_rf_wdata = 0;
      model_reset();
      #12;
      checks++;
      if (ex_valid !== 1'b0 || stall_cnt !== 32'd0 || ex_pc !== 32'd0 || ex_rf_we !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: ex_valid=%b stall_cnt=%0d ex_pc=%h ex_rf_we=%b, required 0/0/0/0",
                  ex_valid, stall_cnt, ex_pc, ex_rf_we);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_back_to_back();
      logic [31:0] pc;
      ex_ready = 1;
      for (int i = 0; i < 3; i++) begin
         pc = 32'h8000_0000 + 32'(4 * i);
         set_id(pc, 5'd1, 1'b1, 5'd2, 1'b1, 5'(10 + i), 1'b1, 1'b0);
         #1;
         checks++;
         if (id_ready !== 1'b1) begin
            errors++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, id_ready);
         end
         cycle();
         checks++;
         if (ex_valid !== 1'b1 || ex_pc !== pc) begin
            errors++; $display("FAIL b2b_pc[%0d]: got valid=%b pc=%h want 1/%h", i, ex_valid, ex_pc, pc);
         end
      end
      id_valid = 0;
      cycle();
      checks++;
      if (ex_valid !== 1'b0 || ex_rf_we !== 1'b0 || ex_mem_re !== 1'b0) begin
         errors++; $display("FAIL drain: got valid=%b we=%b mre=%b want 0/0/0", ex_valid, ex_rf_we, ex_mem_re);
      end
   endtask

   task automatic test_load_use();
      logic [31:0] c0;
      c0 = stall_cnt;
      ex_ready = 1;
      set_id(32'h100, 5'd2, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);    // lw x5
      cycle();
      set_id(32'h104, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0);    // add x6,x5,x1
      #1;
      checks++;
      if (id_ready !== 1'b0) begin
         errors++; $display("FAIL lu_ready_low: got %b want 0", id_ready);
      end
      cycle();
      checks++;
      if (ex_valid !== 1'b0 || stall_cnt !== c0 + 1) begin
         errors++; $display("FAIL lu_bubble: got valid=%b cnt=%0d want 0/%0d", ex_valid, stall_cnt, c0 + 1);
      end
      checks++;
      if (id_ready !== 1'b1) begin
         errors++; $display("FAIL lu_ready_back: got %b want 1", id_ready);
      end
      cycle();
      checks++;
      if (ex_valid !== 1'b1 || ex_pc !== 32'h104 || ex_rf_raddr1 !== 5'd5) begin
         errors++; $display("FAIL lu_add_in_ex: got valid=%b pc=%h ra1=%0d want 1/104/5", ex_valid, ex_pc, ex_rf_raddr1);
      end
      id_valid = 0;
      cycle();
   endtask

   task automatic test_x0_load();
      logic [31:0] c0;
      c0 = stall_cnt;
      ex_ready = 1;
      set_id(32'h200, 5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);    // lw x0
      cycle();
      set_id(32'h204, 5'd0, 1'b1, 5'd0, 1'b1, 5'd8, 1'b1, 1'b0);    // reads x0
      #1;
      checks++;
      if (id_ready !== 1'b1) begin
         errors++; $display("FAIL x0_ready: got %b want 1", id_ready);
      end
      cycle();
      checks++;
      if (ex_valid !== 1'b1 || ex_pc !== 32'h204 || stall_cnt !== c0) begin
         errors++; $display("FAIL x0_no_bubble: got valid=%b pc=%h cnt=%0d want 1/204/%0d", ex_valid, ex_pc, stall_cnt, c0);
      end
      id_valid = 0;
      cycle();
   endtask

   task automatic test_hold_refresh();
      logic [31:0] r2;
      ex_ready = 1;
      set_id(32'h300, 5'd7, 1'b1, 5'd3, 1'b1, 5'd9, 1'b1, 1'b0);
      id_rf_rdata1 = 32'h1111_1111;
      r2 = id_rf_rdata2;
      cycle();
      set_id(32'h304, 5'd4, 1'b1, 5'd4, 1'b1, 5'd4, 1'b1, 1'b0);
      ex_ready = 0;
      for (int c = 1; c <= 5; c++) begin
         wb_rf_we = (c == 2 || c == 3);
         wb_rf_waddr = (c == 3) ? 5'd7 : 5'd12;
         wb_rf_wdata = (c == 3) ? 32'hDEAD_BEEF : 32'h5555_5555;
         #1;
         checks++;
         if (id_ready !== 1'b0) begin
            errors++; $display("FAIL hold_ready[%0d]: got %b want 0", c, id_ready);
         end
         cycle();
         checks++;
         if (ex_rf_rdata1 !== ((c >= 3) ? 32'hDEAD_BEEF : 32'h1111_1111) ||
             ex_rf_rdata2 !== r2 || ex_pc !== 32'h300 || ex_valid !== 1'b1) begin
            errors++;
            $display("FAIL hold_refresh[%0d]: got rd1=%h rd2=%h pc=%h v=%b want rd1=%h rd2=%h pc=300 v=1",
                     c, ex_rf_rdata1, ex_rf_rdata2, ex_pc, ex_valid,
                     (c >= 3) ? 32'hDEAD_BEEF : 32'h1111_1111, r2);
         end
      end
      wb_rf_we = 0;
      ex_ready = 1;
      id_valid = 0;
      cycle();
   endtask

   task automatic test_flush();
      logic [31:0] c0;
      ex_ready = 1;
      set_id(32'h400, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);    // lw x5
      cycle();
      c0 = stall_cnt;
      set_id(32'h404, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0);    // hazard on x5
      flush = 1;
      #1;
      checks++;
      if (id_ready !== 1'b0) begin
         errors++; $display("FAIL flush_ready: got %b want 0", id_ready);
      end
      cycle();
      checks++;
      if (ex_valid !== 1'b0 || stall_cnt !== c0) begin
         errors++; $display("FAIL flush_squash: got valid=%b cnt=%0d want 0/%0d", ex_valid, stall_cnt, c0);
      end
      flush = 0;
      id_valid = 0;
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         set_id($urandom, 5'($urandom_range(0, 7)), 1'($urandom), 5'($urandom_range(0, 7)),
                1'($urandom), 5'($urandom_range(0, 7)), 1'($urandom), ($urandom_range(0, 2) == 0));
         id_valid = ($urandom_range(0, 3) != 0);
         ex_ready = ($urandom_range(0, 2) != 0);
         wb_rf_we = 1'($urandom);
         wb_rf_waddr = 5'($urandom_range(0, 7));
         wb_rf_wdata = $urandom;
         flush = m.valid && ex_ready && ($urandom_range(0, 9) == 0);
         #1;
         checks++;
         if (id_ready !== model_ready()) begin
            errors++; $display("FAIL rnd_ready[%0d]: got %b want %b", n, id_ready, model_ready());
         end
         cycle();
         checks++;
         if (ex_valid !== m.valid || stall_cnt !== m_cnt ||
             ex_rf_we !== (m.valid && m.we) || ex_mem_re !== (m.valid && m.mre)) begin
            errors++;
            $display("FAIL rnd_ctl[%0d]: got v=%b cnt=%0d we=%b mre=%b want v=%b cnt=%0d we=%b mre=%b",
                     n, ex_valid, stall_cnt, ex_rf_we, ex_mem_re, m.valid, m_cnt, m.valid && m.we, m.valid && m.mre);
         end
         if (m.valid) begin
            checks++;
            if (ex_pc !== m.pc || ex_imm !== m.imm || ex_ctrl !== m.ctrl ||
                ex_rf_raddr1 !== m.ra1 || ex_rf_raddr2 !== m.ra2 || ex_rf_waddr !== m.wa ||
                ex_rf_rdata1 !== m.rd1 || ex_rf_rdata2 !== m.rd2) begin
               errors++;
               $display("FAIL rnd_payload[%0d]: got pc=%h imm=%h ctrl=%h ra=%0d/%0d wa=%0d rd=%h/%h want pc=%h imm=%h ctrl=%h ra=%0d/%0d wa=%0d rd=%h/%h",
                        n, ex_pc, ex_imm, ex_ctrl, ex_rf_raddr1, ex_rf_raddr2, ex_rf_waddr, ex_rf_rdata1, ex_rf_rdata2,
                        m.pc, m.imm, m.ctrl, m.ra1, m.ra2, m.wa, m.rd1, m.rd2);
            end
         end
      end
      flush = 0;
      wb_rf_we = 0;
   endtask

   task automatic test_reset_mid_stream();
      ex_ready = 1;
      set_id(32'h500, 5'd1, 1'b0, 5'd2, 1'b0, 5'd3, 1'b1, 1'b0);
      cycle();
      ex_ready = 0;
      id_valid = 0;
      checks++;
      if (ex_valid !== 1'b1 || stall_cnt === 32'd0) begin
         errors++; $display("FAIL pre_reset: got valid=%b cnt=%0d want 1/nonzero", ex_valid, stall_cnt);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (ex_valid !== 1'b0 || stall_cnt !== 32'd0 || ex_pc !== 32'd0 || ex_rf_we !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: got valid=%b cnt=%0d pc=%h we=%b want 0/0/0/0", ex_valid, stall_cnt, ex_pc, ex_rf_we);
      end
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      ex_ready = 1;
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_load_use();
      test_x0_load();
      test_hold_refresh();
      test_flush();
      test_random();
      test_reset_mid_stream();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Bound the whole run so it can never hang
   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
